// File: rtl/game_pkg.sv
// Shared types for the 1A2B round controller: FSM states, history entry
// layout and score sizing.
package game_pkg;

    localparam int SCORE_W = 3;
    localparam int DIGITS  = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GEN,
        WAIT_GUESS,
        LATCH,
        SCORE,
        WIN,
        LOSE
    } state_t;

    typedef struct packed {
        logic [SCORE_W-1:0] a;
        logic [SCORE_W-1:0] b;
    } hist_entry_t;

    // A or B can never exceed the number of digits in a guess
    function automatic logic [SCORE_W-1:0] clamp_score(
        input logic [SCORE_W-1:0] s
    );
        return (s > SCORE_W'(DIGITS)) ? SCORE_W'(DIGITS) : s;
    endfunction

endpackage

// File: rtl/round_history.sv
// Circular store of scored guesses; read index 0 is the newest entry,
// and unwritten slots read back as zero.
module round_history
    import game_pkg::*;
#(
    parameter int HIST_DEPTH = 8,
    parameter int AW         = $clog2(HIST_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          wr_en,
    input  hist_entry_t   wr_data,
    input  logic [AW-1:0] rd_idx,
    output hist_entry_t   rd_data,
    output logic          rd_valid
);

    hist_entry_t   mem [HIST_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW-1:0] rd_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
            if (count != (AW+1)'(HIST_DEPTH)) begin
                count <= count + 1'b1;
            end
        end
    end

    // Pointer arithmetic wraps because the depth is a power of two
    assign rd_addr  = wr_ptr - AW'(1) - rd_idx;
    assign rd_valid = ({1'b0, rd_idx} < count);
    assign rd_data  = rd_valid ? mem[rd_addr] : '0;

endmodule

// File: rtl/game_round_ctrl.sv
// 1A2B round controller: sequences dp secret generation and guess scoring,
// tracks attempts and win/lose, and keeps a history of past scores.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int MAX_TRIES  = 10,
    parameter int HIST_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          submit,
    input  logic                          dp_valid,
    input  logic                          dp_input_error,
    input  logic                          dp_same,
    input  logic [SCORE_W-1:0]            a_num,
    input  logic [SCORE_W-1:0]            b_num,
    output logic                          dp_clear,
    output logic                          save_test,
    output logic                          guess_latch,
    output logic                          busy,
    output logic                          win,
    output logic                          lose,
    output logic                          err_pulse,
    output logic [3:0]                    attempts,
    output logic [SCORE_W-1:0]            last_a,
    output logic [SCORE_W-1:0]            last_b,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
    output logic [2*SCORE_W-1:0]          hist_rd_data,
    output logic                          hist_rd_valid
);

    state_t      state;
    state_t      nxt;
    logic        abort;
    logic        last_try;
    logic        hist_wr;
    hist_entry_t entry;
    hist_entry_t rd_entry;

    assign abort    = start && (state != CLEAR);
    assign last_try = (attempts + 4'd1) == 4'(MAX_TRIES);
    assign hist_wr  = (state == SCORE) && !abort;
    assign entry    = '{a: clamp_score(a_num), b: clamp_score(b_num)};

    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = CLEAR;
        end else begin
            unique case (state)
                IDLE:       nxt = IDLE;
                CLEAR:      nxt = GEN;
                GEN:        nxt = dp_valid ? WAIT_GUESS : GEN;
                WAIT_GUESS: nxt = (submit && !dp_input_error)
                                  ? LATCH : WAIT_GUESS;
                LATCH:      nxt = SCORE;
                SCORE: begin
                    if (dp_same)       nxt = WIN;
                    else if (last_try) nxt = LOSE;
                    else               nxt = WAIT_GUESS;
                end
                WIN:        nxt = WIN;
                LOSE:       nxt = LOSE;
                default:    nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dp_clear    <= 1'b0;
            save_test   <= 1'b0;
            guess_latch <= 1'b0;
            busy        <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
            err_pulse   <= 1'b0;
            attempts    <= '0;
            last_a      <= '0;
            last_b      <= '0;
        end else begin
            state       <= nxt;
            dp_clear    <= (nxt == CLEAR);
            save_test   <= (nxt == GEN);
            guess_latch <= (nxt == LATCH);
            win         <= (nxt == WIN);
            lose        <= (nxt == LOSE);
            busy        <= !(nxt inside {IDLE, WIN, LOSE});
            err_pulse   <= !abort && (state == WAIT_GUESS)
                           && submit && dp_input_error;
            if (abort) begin
                attempts <= '0;
                last_a   <= '0;
                last_b   <= '0;
            end else if (state == SCORE) begin
                attempts <= attempts + 4'd1;
                last_a   <= entry.a;
                last_b   <= entry.b;
            end
        end
    end

    round_history #(
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .clr      (abort),
        .wr_en    (hist_wr),
        .wr_data  (entry),
        .rd_idx   (hist_rd_idx),
        .rd_data  (rd_entry),
        .rd_valid (hist_rd_valid)
    );

    assign hist_rd_data = rd_entry;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with hand-computed expectations.
module tb_game_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic       dp_valid = 1'b0;
    logic       dp_input_error = 1'b0;
    logic       dp_same = 1'b0;
    logic [2:0] a_num = '0;
    logic [2:0] b_num = '0;
    logic       dp_clear, save_test, guess_latch, busy;
    logic       win, lose, err_pulse;
    logic [3:0] attempts;
    logic [2:0] last_a, last_b;
    logic [2:0] hist_rd_idx = '0;
    logic [5:0] hist_rd_data;
    logic       hist_rd_valid;

    int checks = 0;
    int failures = 0;

    game_round_ctrl #(
        .MAX_TRIES  (10),
        .HIST_DEPTH (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .submit         (submit),
        .dp_valid       (dp_valid),
        .dp_input_error (dp_input_error),
        .dp_same        (dp_same),
        .a_num          (a_num),
        .b_num          (b_num),
        .dp_clear       (dp_clear),
        .save_test      (save_test),
        .guess_latch    (guess_latch),
        .busy           (busy),
        .win            (win),
        .lose           (lose),
        .err_pulse      (err_pulse),
        .attempts       (attempts),
        .last_a         (last_a),
        .last_b         (last_b),
        .hist_rd_idx    (hist_rd_idx),
        .hist_rd_data   (hist_rd_data),
        .hist_rd_valid  (hist_rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_hist(input logic [2:0] idx, input logic [5:0] exp,
                           input logic vld, input string tag);
        hist_rd_idx = idx;
        #1;
        check({tag, "_valid"}, 32'(hist_rd_valid), 32'(vld));
        check({tag, "_data"}, 32'(hist_rd_data), 32'(exp));
    endtask

    // Full scored guess; returns one cycle after SCORE
    task automatic guess(input logic [2:0] a, input logic [2:0] b,
                         input logic same);
        a_num = a;
        b_num = b;
        dp_same = same;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        tick();
        tick();
        dp_same = 1'b0;
    endtask

    task automatic begin_round();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dp_valid = 1'b1;
        tick();
        dp_valid = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_clear", 32'(dp_clear), 0);
        check("rst_att", 32'(attempts), 0);
        check("rst_wl", 32'({win, lose}), 0);
        rd_hist(3'd0, 6'd0, 1'b0, "rst_h0");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

        // start, dp_valid three cycles after start
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_clear", 32'(dp_clear), 1);
        check("t1_busy0", 32'(busy), 1);
        check("t1_save0", 32'(save_test), 0);
        tick();
        check("t1_clear_gone", 32'(dp_clear), 0);
        check("t1_save1", 32'(save_test), 1);
        tick();
        check("t1_save2", 32'(save_test), 1);
        check("t1_busy2", 32'(busy), 1);
        dp_valid = 1'b1;
        tick();
        dp_valid = 1'b0;
        check("t1_save_drop", 32'(save_test), 0);
        check("t1_busy3", 32'(busy), 1);

        // first scored guess 1A2B
        a_num = 3'd1;
        b_num = 3'd2;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        check("t2_latch", 32'(guess_latch), 1);
        check("t2_att_pre", 32'(attempts), 0);
        tick();
        check("t2_latch_gone", 32'(guess_latch), 0);
        tick();
        check("t2_last_a", 32'(last_a), 1);
        check("t2_last_b", 32'(last_b), 2);
        check("t2_att", 32'(attempts), 1);
        rd_hist(3'd0, 6'b001_010, 1'b1, "t2_h0");
        rd_hist(3'd1, 6'd0, 1'b0, "t2_h1");

        // rejected guess
        dp_input_error = 1'b1;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        dp_input_error = 1'b0;
        check("t3_err", 32'(err_pulse), 1);
        check("t3_nolatch", 32'(guess_latch), 0);
        tick();
        check("t3_err_gone", 32'(err_pulse), 0);
        check("t3_nolatch2", 32'(guess_latch), 0);
        check("t3_att", 32'(attempts), 1);

        // guesses 2..10, guess k scores a=k%5, b=(3k)%5
        for (int k = 2; k <= 10; k++) begin
            guess(3'(k % 5), 3'((3 * k) % 5), 1'b0);
            if (k == 9) begin
                check("t4_att9", 32'(attempts), 9);
                check("t4_nolose9", 32'(lose), 0);
            end
        end
        check("t4_lose", 32'(lose), 1);
        check("t4_win", 32'(win), 0);
        check("t4_att", 32'(attempts), 10);
        check("t4_busy", 32'(busy), 0);
        rd_hist(3'd0, 6'b000_000, 1'b1, "t4_h0");
        rd_hist(3'd1, 6'b100_010, 1'b1, "t4_h1");
        rd_hist(3'd7, 6'b011_100, 1'b1, "t4_h7");
        submit = 1'b1;
        tick();
        submit = 1'b0;
        check("t4_ign_latch", 32'(guess_latch), 0);
        check("t4_ign_err", 32'(err_pulse), 0);
        check("t4_ign_att", 32'(attempts), 10);

        // new round, win on the final try
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_clr_lose", 32'(lose), 0);
        check("t5_clr_att", 32'(attempts), 0);
        check("t5_clr_pulse", 32'(dp_clear), 1);
        rd_hist(3'd0, 6'd0, 1'b0, "t5_hclr");
        tick();
        dp_valid = 1'b1;
        tick();
        dp_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            guess(3'd0, 3'd1, 1'b0);
        end
        check("t5_att9", 32'(attempts), 9);
        guess(3'd4, 3'd0, 1'b1);
        check("t5_win", 32'(win), 1);
        check("t5_nolose", 32'(lose), 0);
        check("t5_att10", 32'(attempts), 10);
        check("t5_last_a", 32'(last_a), 4);
        rd_hist(3'd0, 6'b100_000, 1'b1, "t5_h0");
        submit = 1'b1;
        tick();
        submit = 1'b0;
        check("t5_ign_latch", 32'(guess_latch), 0);
        check("t5_ign_win", 32'(win), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_rst_win", 32'(win), 0);
        check("t5_rst_att", 32'(attempts), 0);

        // async reset in SCORE, then start beats submit
        tick();
        dp_valid = 1'b1;
        tick();
        dp_valid = 1'b0;
        guess(3'd2, 3'd2, 1'b0);
        check("t6_att1", 32'(attempts), 1);
        submit = 1'b1;
        tick();
        submit = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 0);
        check("t6_att", 32'(attempts), 0);
        check("t6_last_a", 32'(last_a), 0);
        check("t6_clear", 32'(dp_clear), 0);
        rd_hist(3'd0, 6'd0, 1'b0, "t6_h0");
        tick();
        reset = 1'b0;
        tick();
        start = 1'b1;
        submit = 1'b1;
        tick();
        start = 1'b0;
        submit = 1'b0;
        check("t6_clear_go", 32'(dp_clear), 1);
        check("t6_nolatch", 32'(guess_latch), 0);
        check("t6_busy_go", 32'(busy), 1);

        // mid-round restart via begin_round keeps the helper exercised
        begin_round();
        check("t7_wait_busy", 32'(busy), 1);
        check("t7_save", 32'(save_test), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
